bist_engine: RTL



---
 rtl/bist_engine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bist_engine.sv
// Logic BIST engine: an LFSR drives the CUT scan chain and inputs, a MISR compacts the
// responses, and the final signature is compared against a golden value.
module bist_engine #(
    parameter int                 LFSR_W     = 8,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 8'h01,
    parameter int                 N_IN       = 3,
    parameter int                 N_OBS      = 3,
    parameter int                 MISR_W     = 8,
    parameter logic [MISR_W-1:0]  MISR_TAPS  = 8'hB8,
    parameter int                 SCAN_LEN   = 4,
    parameter int                 N_PATTERNS = 16,
    parameter logic [MISR_W-1:0]  GOLDEN     = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              bist_start,
    input  logic              bist_abort,
    input  logic [N_IN-1:0]   func_in,
    input  logic [N_OBS-1:0]  obs,
    output logic [N_IN-1:0]   cut_in,
    output logic              scan_en,
    output logic              scan_in,
    output logic              test_mode,
    output logic              bist_end,
    output logic              pass_fail,
    output logic [MISR_W-1:0] signature,
    output logic [2:0]        state_dbg
);

    localparam int SHIFT_W = $clog2(SCAN_LEN + 1);
    localparam int PAT_W   = $clog2(N_PATTERNS + 1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(N_PATTERNS - 1);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [LFSR_W-1:0]  SEED_EFF   = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q;
    logic [LFSR_W-1:0]    lfsr;
    logic [MISR_W-1:0]    misr;
    logic [MISR_W-1:0]    obs_ext;
    logic [SHIFT_W-1:0]   shift_cnt;
    logic [PAT_W-1:0]     pat_cnt;
    logic                 start_pulse, abort_now;
    logic                 lfsr_load, lfsr_step, misr_clr, misr_step;
    logic                 shift_clr, shift_inc, pat_clr, pat_inc;
    logic                 flags_clr, result_load;

    // Control protocol: bist_start is edge-triggered and only honoured in IDLE/DONE;
    // bist_abort is a level that wins over a same-cycle start.
    assign start_pulse = bist_start & ~start_q & ~bist_abort;
    assign abort_now   = bist_abort & (state_q != S_IDLE);

    always_comb begin
        obs_ext            = '0;
        obs_ext[N_OBS-1:0] = obs;
    end

    always_comb begin
        state_d     = state_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        misr_clr    = 1'b0;
        misr_step   = 1'b0;
        shift_clr   = 1'b0;
        shift_inc   = 1'b0;
        pat_clr     = 1'b0;
        pat_inc     = 1'b0;
        flags_clr   = 1'b0;
        result_load = 1'b0;
        scan_en     = 1'b0;
        test_mode   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) state_d = S_SEED;
            end
            S_SEED: begin
                test_mode = 1'b1;
                lfsr_load = 1'b1;
                misr_clr  = 1'b1;
                shift_clr = 1'b1;
                pat_clr   = 1'b1;
                flags_clr = 1'b1;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                test_mode = 1'b1;
                scan_en   = 1'b1;
                lfsr_step = 1'b1;
                misr_step = 1'b1;
                shift_inc = 1'b1;
                if (shift_cnt == SHIFT_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                test_mode = 1'b1;
                misr_step = 1'b1;
                pat_inc   = 1'b1;
                shift_clr = 1'b1;
                state_d   = (pat_cnt == PAT_LAST) ? S_COMPARE : S_SHIFT;
            end
            S_COMPARE: begin
                test_mode   = 1'b1;
                result_load = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (start_pulse) state_d = S_SEED;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the datapath so the partial signature stays readable.
        if (abort_now) begin
            state_d     = S_IDLE;
            lfsr_load   = 1'b0;
            lfsr_step   = 1'b0;
            misr_clr    = 1'b0;
            misr_step   = 1'b0;
            shift_clr   = 1'b0;
            shift_inc   = 1'b0;
            pat_clr     = 1'b0;
            pat_inc     = 1'b0;
            result_load = 1'b0;
            flags_clr   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            start_q   <= 1'b0;
            lfsr      <= '0;
            misr      <= '0;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
        end else begin
            start_q <= bist_start;

            if (lfsr_load)      lfsr <= SEED_EFF;
            else if (lfsr_step) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

            if (misr_clr)       misr <= '0;
            else if (misr_step) misr <= {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ obs_ext;

            if (shift_clr)      shift_cnt <= '0;
            else if (shift_inc) shift_cnt <= shift_cnt + SHIFT_W'(1);

            if (pat_clr)        pat_cnt <= '0;
            else if (pat_inc)   pat_cnt <= pat_cnt + PAT_W'(1);

            if (flags_clr) begin
                bist_end  <= 1'b0;
                pass_fail <= 1'b0;
            end else if (result_load) begin
                bist_end  <= 1'b1;
                pass_fail <= (misr == GOLDEN);
            end
        end
    end

    assign cut_in    = test_mode ? lfsr[N_IN-1:0] : func_in;
    assign scan_in   = lfsr[LFSR_W-1];
    assign signature = misr;
    assign state_dbg = state_q;

endmodule
